// File: rtl/m7458_pkg.sv
// rtl/m7458_pkg.sv - shared constants, FSM states and golden model for the m7458 vector checker
package m7458_pkg;

   localparam int VEC_W = 10;

   // Fibonacci LFSR x^10+x^7+1: feedback from bits 9 and 6, shifted in at bit 0
   localparam logic [VEC_W-1:0] LFSR_TAPS = 10'h240;
   localparam logic [VEC_W-1:0] LFSR_SEED = 10'h001;
   localparam logic [VEC_W-1:0] LFSR_LAST = 10'h200;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   // Returns {p1y, p2y}; bit 9 = p1a ... bit 4 = p1f, bit 3 = p2a ... bit 0 = p2d
   function automatic logic [1:0] m7458_golden(input logic [VEC_W-1:0] vec);
      logic p1y;
      logic p2y;
      p1y = (vec[9] & vec[8] & vec[7]) | (vec[6] & vec[5] & vec[4]);
      p2y = (vec[3] & vec[2]) | (vec[1] & vec[0]);
      return {p1y, p2y};
   endfunction

endpackage

// File: rtl/m7458_vec_gen.sv
// rtl/m7458_vec_gen.sv - stimulus vector register; incrementing order, or LFSR order under M7458_LFSR_STIM_EN
module m7458_vec_gen
   import m7458_pkg::*;
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             advance,
   output logic [VEC_W-1:0] vec,
   output logic             last
);

   logic [VEC_W-1:0] vec_next;

`ifdef M7458_LFSR_STIM_EN
   // Vector 0 leads the sweep; the LFSR then visits all 1023 nonzero states
   always_comb begin
      if (vec == '0) vec_next = LFSR_SEED;
      else           vec_next = {vec[VEC_W-2:0], ^(vec & LFSR_TAPS)};
   end
   assign last = (vec == LFSR_LAST);
`else
   assign vec_next = vec + VEC_W'(1);
   assign last     = (vec == '1);
`endif

   always_ff @(posedge clk) begin
      if (!resetn)      vec <= '0;
      else if (load)    vec <= '0;
      else if (advance) vec <= vec_next;
   end

endmodule

// File: rtl/m7458_vec_checker.sv
// rtl/m7458_vec_checker.sv - sweeps all m7458 input vectors and checks responses (LFSR order: M7458_LFSR_STIM_EN)
module m7458_vec_checker
   import m7458_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 11
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   output logic [VEC_W-1:0] stim,
   input  logic             dut_p1y,
   input  logic             dut_p2y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [VEC_W-1:0] first_err_vec
);

   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
   // With no settle time a vector goes straight to its sample cycle
   localparam state_t VEC_ENTRY = (SETTLE > 0) ? DRIVE : SAMPLE;

   state_t     state;
   state_t     state_next;
   logic [3:0] settle_cnt;
   logic       accept;
   logic       advance;
   logic       last;
   logic       mismatch;

   m7458_vec_gen u_vec_gen (
      .clk     (clk),
      .resetn  (resetn),
      .load    (accept),
      .advance (advance),
      .vec     (stim),
      .last    (last)
   );

   assign mismatch = ({dut_p1y, dut_p2y} != m7458_golden(stim));
   assign pass     = done && (err_cnt == '0);

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      advance    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = VEC_ENTRY;
            end
         end
         DRIVE: begin
            busy = 1'b1;
            if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
         end
         SAMPLE: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end else begin
               advance    = 1'b1;
               state_next = VEC_ENTRY;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = VEC_ENTRY;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn || state != DRIVE) settle_cnt <= '0;
      else                           settle_cnt <= settle_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn || accept) begin
         err_cnt       <= '0;
         first_err_vec <= '0;
      end else if (state == SAMPLE && mismatch) begin
         err_cnt <= err_cnt + CNT_W'(1);
         if (err_cnt == '0) first_err_vec <= stim;
      end
   end

endmodule
